systolic_result_reader: RTL and testbench

SYSTOLIC_RESULT_READER -- requirements
Module: systolic_result_reader

---
 rtl/systolic_result_reader.sv | 138 +++++++++++++
 tb/tb_systolic_result_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_reader.sv
// Streams NUM_ROWS result rows out of the systolic array's result SRAM.
// A two-entry skid FIFO buffers the rows and applies valid/ready flow control.
module systolic_result_reader #(
  parameter int ROW_WIDTH = 512,
  parameter int NUM_ROWS  = 128
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 read_start,
  output logic                 sram_read_enable,
  output logic [6:0]           sram_raddr,
  input  logic [ROW_WIDTH-1:0] sram_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_WIDTH-1:0] out_data,
  output logic [6:0]           out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 read_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [6:0] LAST_ADDR = 7'(NUM_ROWS - 1);

  state_t state_reg, state_next;
  logic [6:0] addr_reg, addr_next, issue_addr;
  logic       rd_en_reg, rd_en_next;
  logic [6:0] raddr_reg, raddr_next;
  logic       rvalid_reg;
  logic [6:0] rindex_reg;
  logic       busy_reg, done_reg;

  logic [ROW_WIDTH-1:0] fifo_data [2];
  logic [6:0]           fifo_index [2];
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic [1:0]           count_reg, count_next;

  logic       bypass, pop, push_store, pop_store;
  logic [2:0] pending;

  // Returning data is visible on the output in its own cycle while the FIFO is empty.
  assign bypass    = (count_reg == 2'd0) && rvalid_reg;
  assign out_valid = (count_reg != 2'd0) || rvalid_reg;

  always_comb begin
    out_data  = '0;
    out_index = '0;
    if (count_reg != 2'd0) begin
      out_data  = fifo_data[rd_ptr_reg];
      out_index = fifo_index[rd_ptr_reg];
    end else if (rvalid_reg) begin
      out_data  = sram_rdata;
      out_index = rindex_reg;
    end
  end

  assign out_last   = out_valid && (out_index == LAST_ADDR);
  assign pop        = out_valid && out_ready;
  assign push_store = rvalid_reg && !(bypass && pop);
  assign pop_store  = pop && (count_reg != 2'd0);

  always_comb begin
    count_next = count_reg;
    if (push_store && !pop_store)
      count_next = count_reg + 2'd1;
    else if (pop_store && !push_store)
      count_next = count_reg - 2'd1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (read_start) state_next = READ;
      READ:    if (rd_en_reg && (raddr_reg == LAST_ADDR)) state_next = DRAIN;
      DRAIN:   if (pop && out_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The next strobe is allowed only if buffered rows plus the read returning
  // alongside it stay below two, so the FIFO can never overflow.
  always_comb begin
    issue_addr = (state_reg == IDLE) ? 7'd0 : addr_reg;
    pending    = {1'b0, count_next} + {2'b00, rd_en_reg};
    rd_en_next = (state_next == READ) && (pending < 3'd2);
    addr_next  = issue_addr;
    raddr_next = raddr_reg;
    if (rd_en_next) begin
      raddr_next = issue_addr;
      if (issue_addr != LAST_ADDR)
        addr_next = issue_addr + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      rd_en_reg  <= 1'b0;
      raddr_reg  <= '0;
      rvalid_reg <= 1'b0;
      rindex_reg <= '0;
      count_reg  <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      rd_en_reg  <= rd_en_next;
      raddr_reg  <= raddr_next;
      rvalid_reg <= rd_en_reg;
      rindex_reg <= raddr_reg;
      count_reg  <= count_next;
      if (push_store) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_store)  rd_ptr_reg <= ~rd_ptr_reg;
      busy_reg   <= (state_next != IDLE);
      done_reg   <= (state_next == FINISH);
    end
  end

  // Storage needs no reset: the occupancy count gates every read of it.
  always_ff @(posedge clk) begin
    if (!srst && push_store) begin
      fifo_data[wr_ptr_reg]  <= sram_rdata;
      fifo_index[wr_ptr_reg] <= rindex_reg;
    end
  end

  assign sram_read_enable = rd_en_reg;
  assign sram_raddr       = raddr_reg;
  assign busy             = busy_reg;
  assign read_done        = done_reg;

endmodule

// File: tb/tb_systolic_result_reader.sv
// Directed job sequence with randomized data tags and ready patterns; a scoreboard
// tracks the expected row order, issued strobes and completion timing.
module tb_systolic_result_reader;
  localparam int RW = 512;
  localparam int NR = 128;

  logic          clk = 1'b0;
  logic          srst;
  logic          read_start;
  logic          sram_read_enable;
  logic [6:0]    sram_raddr;
  logic [RW-1:0] sram_rdata = '0;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [6:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          read_done;

  always #5 clk = ~clk;

  systolic_result_reader #(.ROW_WIDTH(RW), .NUM_ROWS(NR)) dut (
    .clk(clk), .srst(srst), .read_start(read_start),
    .sram_read_enable(sram_read_enable), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .read_done(read_done)
  );

  logic [31:0] tag = 32'd0;

  function automatic logic [RW-1:0] row_val(int k, logic [31:0] t);
    return {{15{t}}, 32'(k)};
  endfunction

  // SRAM model: data appears one cycle after the strobe.
  always @(posedge clk) if (sram_read_enable) sram_rdata <= row_val(int'(sram_raddr), tag);

  int errors = 0, checks = 0, cyc = 0;
  int exp_idx, issued, n0, done_cnt, done_cyc, last_accept_cyc;
  bit active, full_rate;
  bit prev_valid, prev_ready, prev_pop, prev_full;
  logic [RW-1:0] prev_data;
  logic [6:0] prev_index;

  task automatic chk_int(string name, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic chk_row(string name, logic [RW-1:0] obs, logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic observe();
    if (prev_pop && prev_full && issued < NR)
      chk_int("resume_after_pop", int'(sram_read_enable), 1);
    if (prev_valid && !prev_ready) begin
      chk_int("hold_valid", int'(out_valid), 1);
      chk_int("hold_index", int'(out_index), int'(prev_index));
      chk_row("hold_data", out_data, prev_data);
    end
    if (sram_read_enable) begin
      chk_int("raddr_seq", int'(sram_raddr), issued);
      if (issued == 0 && full_rate) chk_int("first_strobe_cycle", cyc, n0 + 1);
      issued++;
      chk_int("outstanding_le2", int'((issued - exp_idx) <= 2), 1);
    end
    prev_full = ((issued - exp_idx) == 2);
    if (out_valid) chk_int("last_flag", int'(out_last), int'(out_index == 7'(NR - 1)));
    if (out_valid || sram_read_enable || read_done) chk_int("busy_active", int'(busy), 1);
    if (out_valid && out_ready) begin
      chk_int("beat_index", int'(out_index), exp_idx);
      chk_row("beat_data", out_data, row_val(exp_idx, tag));
      chk_int("beat_last", int'(out_last), int'(exp_idx == NR - 1));
      if (full_rate) chk_int("beat_cycle", cyc, n0 + 2 + exp_idx);
      last_accept_cyc = cyc;
      exp_idx++;
    end
    if (read_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk_int("done_timing", cyc, last_accept_cyc + 1);
      chk_int("done_after_all", exp_idx, NR);
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_pop   = out_valid && out_ready;
    prev_data  = out_data;
    prev_index = out_index;
  endtask

  task automatic tick();
    @(negedge clk);
    if (active) observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(string name);
    chk_int({name, "_en"}, int'(sram_read_enable), 0);
    chk_int({name, "_raddr"}, int'(sram_raddr), 0);
    chk_int({name, "_valid"}, int'(out_valid), 0);
    chk_row({name, "_data"}, out_data, '0);
    chk_int({name, "_index"}, int'(out_index), 0);
    chk_int({name, "_last"}, int'(out_last), 0);
    chk_int({name, "_busy"}, int'(busy), 0);
    chk_int({name, "_done"}, int'(read_done), 0);
  endtask

  // mode: 0 full rate, 1 backpressure at beat 5, 2 random ready,
  //       3 extra read_start at beat 40, 4 reset at beat 60, 5 last-beat stall
  task automatic run_job(int mode);
    int stall = 0;
    bit stall_started = 0, pulsed = 0, finished = 0;
    exp_idx = 0; issued = 0; done_cnt = 0; done_cyc = -100; last_accept_cyc = -100;
    prev_valid = 0; prev_ready = 0; prev_pop = 0; prev_full = 0;
    tag = (mode == 0) ? 32'd0 : $urandom;
    full_rate = (mode == 0);
    active = 1;
    out_ready = 1'b1;
    read_start = 1'b1;
    n0 = cyc;
    tick();
    read_start = 1'b0;
    for (int t = 0; t < 3000 && !finished; t++) begin
      read_start = 1'b0;
      out_ready = 1'b1;
      case (mode)
        1: begin
          if (exp_idx == 5 && !stall_started) begin stall_started = 1; stall = 10; end
          if (stall > 0) begin out_ready = 1'b0; stall--; end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        3: if (exp_idx == 40 && !pulsed) begin pulsed = 1; read_start = 1'b1; end
        4: if (exp_idx == 60 && out_valid) begin
          active = 0;
          out_ready = 1'b0;
          srst = 1'b1;
          tick();
          srst = 1'b0;
          check_all_zero("abort_reset");
          for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            tick();
            chk_int("abort_idle_valid", int'(out_valid), 0);
            chk_int("abort_idle_done", int'(read_done), 0);
            chk_int("abort_idle_busy", int'(busy), 0);
          end
          finished = 1;
        end
        5: begin
          if (out_valid && out_last && !stall_started) begin stall_started = 1; stall = 5; end
          if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
            chk_int("last_stall_done", int'(read_done), 0);
            chk_int("last_stall_busy", int'(busy), 1);
            chk_int("last_stall_valid", int'(out_valid), 1);
          end
        end
        default: ;
      endcase
      if (!finished) begin
        tick();
        if (done_cnt > 0 && (cyc - done_cyc) >= 5) finished = 1;
      end
    end
    active = 0;
    read_start = 1'b0;
    if (mode == 4) begin
      chk_int("abort_no_done", done_cnt, 0);
    end else begin
      chk_int("job_beats", exp_idx, NR);
      chk_int("job_strobes", issued, NR);
      chk_int("job_done_count", done_cnt, 1);
      chk_int("job_idle_busy", int'(busy), 0);
      if (mode == 5) chk_int("last_stall_seen", int'(stall_started), 1);
    end
    $display("job mode=%0d tag=%08h beats=%0d strobes=%0d done=%0d", mode, tag, exp_idx, issued, done_cnt);
  endtask

  initial begin
    active = 0;
    srst = 1'b1;
    read_start = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset_state");
    srst = 1'b0;
    tick();
    check_all_zero("idle_state");
    run_job(0);
    run_job(1);
    run_job(2);
    run_job(3);
    run_job(4);
    run_job(0);
    run_job(2);
    run_job(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
